code_fetch_unpack: RTL and testbench



---
 rtl/code_fetch_unpack_pkg.sv | 24 ++
 rtl/code_fetch_unpack.sv | 102 ++++++++++
 tb/tb_code_fetch_unpack.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/code_fetch_unpack_pkg.sv
// Shared definitions for the code-side fetch/unpack stage: widths, fetch
// state encoding and the minimum flush residence.
package code_fetch_unpack_pkg;

  localparam int BLOCK_W_DEF   = 64;
  localparam int INSTR_W_DEF   = 32;
  localparam int ADDR_W_DEF    = 13;
  localparam int FLUSH_MIN_CYC = 2;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_WAIT  = 3'd1;
  localparam logic [2:0] ST_ISSUE_LO = 3'd2;
  localparam logic [2:0] ST_ISSUE_HI = 3'd3;
  localparam logic [2:0] ST_FLUSH    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_RD_WAIT  = ST_RD_WAIT,
    S_ISSUE_LO = ST_ISSUE_LO,
    S_ISSUE_HI = ST_ISSUE_HI,
    S_FLUSH    = ST_FLUSH
  } fetch_state_e;

endpackage

// File: rtl/code_fetch_unpack.sv
// Pops decrypted 64-bit blocks from the code FIFO and hands them to decode as
// two 32-bit instructions with a running {block, half} PC; branches flush.
module code_fetch_unpack
  import code_fetch_unpack_pkg::*;
#(
  parameter int BLOCK_W = BLOCK_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BLOCK_W-1:0] fifo_dout,
  input  logic               fifo_empty,
  input  logic               fifo_rd_rst_busy,
  output logic               fifo_rd_en,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               branch_half,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W:0]    instr_pc,
  output logic               fetch_starved
);

  fetch_state_e       state_q;
  fetch_state_e       state_d;
  logic [BLOCK_W-1:0] block_q;
  logic               skip_lo_q;
  logic [ADDR_W:0]    pc_q;
  logic [1:0]         flush_cnt_q;

  logic xfer;
  logic rd_ok;
  logic flush_done;

  assign xfer       = instr_valid & instr_ready;
  assign rd_ok      = ~fifo_empty & ~fifo_rd_rst_busy;
  assign flush_done = (flush_cnt_q >= 2'(FLUSH_MIN_CYC - 1)) & ~fifo_rd_rst_busy;

  // A branch overrides every state, including a pop that would start now.
  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    if (branch_taken) begin
      state_d = S_FLUSH;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rd_ok) begin
            fifo_rd_en = 1'b1;
            state_d    = S_RD_WAIT;
          end
        end
        S_RD_WAIT:  state_d = skip_lo_q ? S_ISSUE_HI : S_ISSUE_LO;
        S_ISSUE_LO: if (xfer) state_d = S_ISSUE_HI;
        S_ISSUE_HI: if (xfer) state_d = S_IDLE;
        S_FLUSH:    if (flush_done) state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
    if (reset) begin
      fifo_rd_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      block_q     <= '0;
      skip_lo_q   <= 1'b0;
      pc_q        <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (branch_taken) begin
        // Target wins over a same-cycle increment; the word in flight is dropped.
        pc_q        <= {branch_target, branch_half};
        skip_lo_q   <= branch_half;
        flush_cnt_q <= '0;
      end else begin
        if (xfer) begin
          pc_q <= pc_q + (ADDR_W+1)'(1);
        end
        if (state_q == S_RD_WAIT) begin
          block_q   <= fifo_dout;
          skip_lo_q <= 1'b0;
        end
        if (state_q == S_FLUSH && flush_cnt_q != 2'b11) begin
          flush_cnt_q <= flush_cnt_q + 2'd1;
        end
      end
    end
  end

  assign instr_valid   = (state_q == S_ISSUE_LO) | (state_q == S_ISSUE_HI);
  assign instr         = (state_q == S_ISSUE_HI) ? block_q[BLOCK_W-1:INSTR_W]
                                                 : block_q[INSTR_W-1:0];
  assign instr_pc      = pc_q;
  assign fetch_starved = (state_q == S_IDLE) & fifo_empty;

endmodule

// File: tb/tb_code_fetch_unpack.sv
// Bench for code_fetch_unpack: FIFO model, instruction-stream reference model,
// directed scenarios with literal expectations and a randomized phase.
module tb_code_fetch_unpack;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_rst_busy;
  logic        fifo_rd_en;
  logic        branch_taken;
  logic [12:0] branch_target;
  logic        branch_half;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [13:0] instr_pc;
  logic        fetch_starved;

  always #5 clk = ~clk;

  code_fetch_unpack dut (
    .clk              (clk),
    .reset            (reset),
    .fifo_dout        (fifo_dout),
    .fifo_empty       (fifo_empty),
    .fifo_rd_rst_busy (fifo_rd_rst_busy),
    .fifo_rd_en       (fifo_rd_en),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .branch_half      (branch_half),
    .instr            (instr),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_pc         (instr_pc),
    .fetch_starved    (fetch_starved)
  );

  typedef struct packed {
    logic [31:0] ins;
    logic [13:0] pc;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] fq[$];
  exp_t        eq[$];
  exp_t        cur_e;
  logic [13:0] m_pc;
  bit          m_skip;
  logic [63:0] pend_word;
  bit          pend_valid;
  int          busy_left;
  bit          hold_v;
  logic [31:0] hold_ins;
  logic [13:0] hold_pc;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endfunction

  function automatic exp_t mk(logic [31:0] ins, logic [13:0] pc);
    exp_t e;
    e.ins = ins;
    e.pc  = pc;
    return e;
  endfunction

  // Expected stream: every block pushed since the last branch/reset, in order.
  task automatic push_block(input logic [63:0] w);
    fq.push_back(w);
    if (m_skip) begin
      eq.push_back(mk(w[63:32], m_pc));
      m_pc   = m_pc + 14'd1;
      m_skip = 0;
    end else begin
      eq.push_back(mk(w[31:0], m_pc));
      eq.push_back(mk(w[63:32], m_pc + 14'd1));
      m_pc = m_pc + 14'd2;
    end
    fifo_empty = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    branch_taken     = 1'b0;
    fifo_dout        = pend_valid ? pend_word : {$urandom, $urandom};
    pend_valid       = 0;
    fifo_rd_rst_busy = (busy_left > 0);
    if (busy_left > 0) busy_left--;
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic take(input logic [31:0] ei, input logic [13:0] ep,
                      input bit br, input logic [12:0] bt, input bit bh);
    bit got;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      instr_ready = 1'b1;
      #1;
      if (instr_valid) begin
        got = 1;
        chk("take_instr", 64'(instr), 64'(ei));
        chk("take_pc", 64'(instr_pc), 64'(ep));
        if (br) begin
          branch_taken  = 1'b1;
          branch_target = bt;
          branch_half   = bh;
        end
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL take_timeout: instr_valid never rose, want pc %0h", ep);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (reset) begin
      eq.delete();
      fq.delete();
      m_pc       = '0;
      m_skip     = 0;
      hold_v     = 0;
      pend_valid = 0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(instr_valid), 64'd1);
        chk("hold_instr", 64'(instr), 64'(hold_ins));
        chk("hold_pc", 64'(instr_pc), 64'(hold_pc));
      end
      hold_v   = instr_valid && !instr_ready && !branch_taken;
      hold_ins = instr;
      hold_pc  = instr_pc;
      if (fetch_starved) chk("starved_needs_empty", 64'(fifo_empty), 64'd1);
      if (fifo_rd_en) begin
        chk("rd_legal", 64'({fifo_empty, fifo_rd_rst_busy, branch_taken, instr_valid}), 64'd0);
        if (fq.size() > 0) begin
          pend_word  = fq.pop_front();
          pend_valid = 1;
        end
      end
      if (instr_valid && instr_ready) begin
        if (eq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL xfer_unexpected: got instr %0h pc %0h, want no transfer", instr, instr_pc);
        end else begin
          cur_e = eq.pop_front();
          chk("xfer_instr", 64'(instr), 64'(cur_e.ins));
          chk("xfer_pc", 64'(instr_pc), 64'(cur_e.pc));
        end
      end
      if (branch_taken) begin
        eq.delete();
        fq.delete();
        m_pc       = {branch_target, branch_half};
        m_skip     = branch_half;
        pend_valid = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; fifo_dout = '0; fifo_empty = 1'b1; fifo_rd_rst_busy = 1'b0;
    branch_taken = 1'b0; branch_target = '0; branch_half = 1'b0; instr_ready = 1'b0;
    busy_left = 0; pend_valid = 0; hold_v = 0; m_pc = '0; m_skip = 0;
    repeat (3) tick();
    tick(); reset = 1'b0; #1;
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_pc", 64'(instr_pc), 64'd0);
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst_starved", 64'(fetch_starved), 64'd1);

    // Basic issue with two-cycle latency.
    instr_ready = 1'b1;
    tick(); push_block(64'hAAAA_BBBB_1111_2222); #1;
    chk("basic_rd_en", 64'(fifo_rd_en), 64'd1);
    chk("basic_starved", 64'(fetch_starved), 64'd0);
    tick(); #1;
    chk("basic_rd_pulse", 64'(fifo_rd_en), 64'd0);
    chk("basic_valid_early", 64'(instr_valid), 64'd0);
    tick(); #1;
    chk("basic_valid", 64'(instr_valid), 64'd1);
    chk("basic_lo", 64'(instr), 64'h1111_2222);
    chk("basic_lo_pc", 64'(instr_pc), 64'd0);
    tick(); #1;
    chk("basic_hi", 64'(instr), 64'hAAAA_BBBB);
    chk("basic_hi_pc", 64'(instr_pc), 64'd1);
    tick(); #1;
    chk("basic_idle", 64'(instr_valid), 64'd0);

    // Backpressure: low half stalled, next block waiting in the FIFO.
    instr_ready = 1'b0;
    tick(); push_block(64'h0C0C_0C0C_0D0D_0D0D); #1;
    tick(); #1;
    tick(); push_block(64'h0E0E_0E0E_0F0F_0F0F); #1;
    chk("bp_valid", 64'(instr_valid), 64'd1);
    chk("bp_instr", 64'(instr), 64'h0D0D_0D0D);
    chk("bp_pc", 64'(instr_pc), 64'd2);
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      chk("bp_stall_valid", 64'(instr_valid), 64'd1);
      chk("bp_stall_instr", 64'(instr), 64'h0D0D_0D0D);
      chk("bp_no_prefetch", 64'(fifo_rd_en), 64'd0);
    end
    take(32'h0D0D_0D0D, 14'd2, 0, '0, 0);
    take(32'h0C0C_0C0C, 14'd3, 0, '0, 0);
    take(32'h0F0F_0F0F, 14'd4, 0, '0, 0);
    take(32'h0E0E_0E0E, 14'd5, 0, '0, 0);

    // Branch while the high half is pending, target in upper half.
    tick(); push_block(64'h0123_4567_89AB_CDEF); #1;
    take(32'h89AB_CDEF, 14'd6, 0, '0, 0);
    tick(); instr_ready = 1'b0; #1;
    chk("br_hi_instr", 64'(instr), 64'h0123_4567);
    chk("br_hi_pc", 64'(instr_pc), 64'd7);
    branch_taken = 1'b1; branch_target = 13'h005; branch_half = 1'b1; busy_left = 3;
    tick(); push_block(64'hCAFE_F00D_DEAD_BEEF); #1;
    chk("br_valid_drop", 64'(instr_valid), 64'd0);
    chk("br_busy_no_rd", 64'(fifo_rd_en), 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      chk("br_busy_no_rd", 64'(fifo_rd_en), 64'd0);
    end
    take(32'hCAFE_F00D, 14'h00B, 0, '0, 0);

    // Branch on the same cycle as the low-half handshake.
    tick(); push_block(64'h1111_1111_2222_2222); #1;
    take(32'h2222_2222, 14'h00C, 1, 13'h0A0, 0);
    tick(); #1;
    chk("sim_valid_drop", 64'(instr_valid), 64'd0);
    tick(); push_block(64'h7777_7777_8888_8888); #1;
    take(32'h8888_8888, 14'h140, 0, '0, 0);
    take(32'h7777_7777, 14'h141, 0, '0, 0);

    // PC wrap from the top of the address space.
    tick(); branch_taken = 1'b1; branch_target = 13'h1FFF; branch_half = 1'b1; #1;
    tick(); push_block(64'h9A9A_9A9A_9B9B_9B9B); push_block(64'h9C9C_9C9C_9D9D_9D9D); #1;
    take(32'h9A9A_9A9A, 14'h3FFF, 0, '0, 0);
    take(32'h9D9D_9D9D, 14'h0000, 0, '0, 0);
    take(32'h9C9C_9C9C, 14'h0001, 0, '0, 0);

    // Reset while the popped word sits on fifo_dout.
    tick(); push_block(64'h5555_5555_6666_6666); #1;
    chk("rw_rd_en", 64'(fifo_rd_en), 64'd1);
    tick(); reset = 1'b1; #1;
    tick(); reset = 1'b0; #1;
    chk("rw_valid", 64'(instr_valid), 64'd0);
    chk("rw_pc", 64'(instr_pc), 64'd0);
    chk("rw_instr", 64'(instr), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("rw_no_issue", 64'(instr_valid), 64'd0);
    end

    // Randomized traffic with branches, flush delays and backpressure.
    for (int c = 0; c < 3000; c++) begin
      tick();
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        branch_taken  = 1'b1;
        branch_target = 13'($urandom);
        branch_half   = 1'($urandom);
        busy_left     = $urandom_range(0, 3);
      end else if (!fifo_rd_rst_busy && fq.size() < 3 && $urandom_range(0, 2) == 0) begin
        push_block({$urandom, $urandom});
      end
      #1;
    end
    for (int c = 0; c < 60; c++) begin
      tick(); instr_ready = 1'b1; #1;
    end
    chk("drain_expected_left", 64'(eq.size()), 64'd0);
    chk("drain_fifo_left", 64'(fq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
